// File: rtl/decode_stage_pipe_if.sv
// Purpose: ID-side request and ID/EX-side result signals of decode_stage_pipe.
// Ports:   master = upstream/downstream environment (drives id_*, ex_ready),
//          slave  = the decode stage (drives id_ready and the ex_* payload).
interface decode_stage_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32
);
  localparam int RW = $clog2(NUM_REGS);

  // IF/ID -> decode
  logic             id_valid;
  logic             id_ready;
  logic [WIDTH-1:0] id_pc;
  logic [31:0]      id_instr;

  // ID/EX -> execute
  logic             ex_ready;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc;
  logic [WIDTH-1:0] ex_reg_data1;
  logic [WIDTH-1:0] ex_reg_data2;
  logic [WIDTH-1:0] ex_imm;
  logic [RW-1:0]    ex_rs1;
  logic [RW-1:0]    ex_rs2;
  logic [RW-1:0]    ex_rd;
  logic [2:0]       ex_funct3;
  logic [6:0]       ex_funct7;
  logic [6:0]       ex_opcode;

  modport master (
    output id_valid, id_pc, id_instr, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_reg_data1, ex_reg_data2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_opcode
  );

  modport slave (
    input  id_valid, id_pc, id_instr, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_reg_data1, ex_reg_data2, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_opcode
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Purpose: RV32I decode + register file + ID/EX register, load-use bubble, flush.
// Latency: 1 cycle from id_valid && id_ready to ex_valid.
// Backpressure: ID/EX holds while ex_valid && !ex_ready; id_ready drops then and on load-use hazards.
// Ports: clk, rst (async, active-low), flush, wb_en/wb_rd/wb_data (write-back),
//        stall_cnt (saturating bubble count), bus (decode_stage_pipe_if.slave).
// Option: DECODE_WB_BYPASS_EN makes same-cycle write-back visible on the read ports.
module decode_stage_pipe #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 16,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [RW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [CNT_W-1:0] stall_cnt,
  decode_stage_pipe_if.slave bus
);
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic [RW-1:0]    rd;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [6:0]       opcode;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];

  // Field extraction
  logic [31:0]      instr;
  logic [6:0]       opcode;
  logic [4:0]       rs1_f, rs2_f, rd_f;
  logic [RW-1:0]    rs1, rs2, rd;
  logic [31:0]      imm32;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] rdata1, rdata2;
  logic             uses_rs1, uses_rs2, adv, hazard;

  assign instr  = bus.id_instr;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  // Smaller register files only look at the low index bits.
  assign rs1    = rs1_f[RW-1:0];
  assign rs2    = rs2_f[RW-1:0];
  assign rd     = rd_f[RW-1:0];

  always_comb begin
    imm32 = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'b0};
      OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:                  imm32 = '0;
    endcase
  end
  // Signed size cast sign-extends the 32-bit immediate to WIDTH.
  assign imm = WIDTH'($signed(imm32));

  assign uses_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
  assign uses_rs2 = (opcode == OP_REG || opcode == OP_STORE || opcode == OP_BRANCH);

  // Register file read ports
  always_comb begin
`ifdef DECODE_WB_BYPASS_EN
    rdata1 = (wb_en && wb_rd != '0 && wb_rd == rs1) ? wb_data : regs_q[rs1];
    rdata2 = (wb_en && wb_rd != '0 && wb_rd == rs2) ? wb_data : regs_q[rs2];
`else
    rdata1 = regs_q[rs1];
    rdata2 = regs_q[rs2];
`endif
    if (rs1 == '0) rdata1 = '0;
    if (rs2 == '0) rdata2 = '0;
  end

  // Register file write port; x0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_rd != '0) regs_d[wb_rd] = wb_data;
  end

  // A load in ID/EX whose destination feeds the instruction in ID forces one bubble.
  assign adv    = !ex_q.valid || bus.ex_ready;
  assign hazard = ex_q.valid && ex_q.opcode == OP_LOAD && ex_q.rd != '0 &&
                  ((uses_rs1 && rs1 == ex_q.rd) || (uses_rs2 && rs2 == ex_q.rd));

  assign bus.id_ready = flush || (adv && !hazard);

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      ex_d.valid = 1'b0;
    end else if (adv && hazard && bus.id_valid) begin
      ex_d.valid = 1'b0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (adv) begin
      ex_d.valid  = bus.id_valid;
      ex_d.pc     = bus.id_pc;
      ex_d.rd1    = rdata1;
      ex_d.rd2    = rdata2;
      ex_d.imm    = imm;
      ex_d.rs1    = rs1;
      ex_d.rs2    = rs2;
      ex_d.rd     = rd;
      ex_d.funct3 = instr[14:12];
      ex_d.funct7 = instr[31:25];
      ex_d.opcode = opcode;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_reg_data1 = ex_q.rd1;
  assign bus.ex_reg_data2 = ex_q.rd2;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_funct3    = ex_q.funct3;
  assign bus.ex_funct7    = ex_q.funct7;
  assign bus.ex_opcode    = ex_q.opcode;
  assign stall_cnt        = stall_cnt_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: reset, decode, load-use bubble,
// backpressure hold, flush, write-back read timing and counter saturation.
module tb_decode_stage_pipe;
  localparam int CNT_W = 2;

  localparam logic [31:0] ADD_1_5_0  = 32'h000280B3;  // add  x1,x5,x0
  localparam logic [31:0] ADDI_6_5_M = 32'hFFF28313;  // addi x6,x5,-1
  localparam logic [31:0] BEQ_M4     = 32'hFE000EE3;  // beq  x0,x0,-4
  localparam logic [31:0] LUI_8      = 32'h12345437;  // lui  x8,0x12345
  localparam logic [31:0] LW_3_2     = 32'h00012183;  // lw   x3,0(x2)
  localparam logic [31:0] ADD_4_3_1  = 32'h00118233;  // add  x4,x3,x1
  localparam logic [31:0] LW_0_2     = 32'h00012003;  // lw   x0,0(x2)
  localparam logic [31:0] ADD_4_0_1  = 32'h00100233;  // add  x4,x0,x1
  localparam logic [31:0] ADDI_9_7_0 = 32'h00038493;  // addi x9,x7,0

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] stall_cnt;
  int               n_tests = 0;
  int               n_fail  = 0;
  logic [31:0]      exp_cnt;

  decode_stage_pipe_if #(.WIDTH(32), .NUM_REGS(32)) bus ();

  decode_stage_pipe #(.WIDTH(32), .NUM_REGS(32), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .stall_cnt (stall_cnt),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
    bus.id_valid = 1'b1;
    bus.id_pc    = pc;
    bus.id_instr = instr;
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_rd   = rd;
    wb_data = data;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_instr = '0; bus.ex_ready = 1'b1;
    #12;
    chk("reset_ex_valid", 32'(bus.ex_valid), 0);
    chk("reset_stall_cnt", 32'(stall_cnt), 0);
    chk("reset_id_ready", 32'(bus.id_ready), 1);
    rst = 1'b1;
    tick();

    wr(5'd5, 32'hDEADBEEF);
    wr(5'd1, 32'h00000011);
    wr(5'd2, 32'h00000200);
    wr(5'd7, 32'h00000077);
    wr(5'd0, 32'hFFFFFFFF);

    // Plain R-type issue
    drive(32'h100, ADD_1_5_0);
    chk("add_id_ready", 32'(bus.id_ready), 1);
    tick();
    bus.id_valid = 1'b0;
    chk("add_ex_valid", 32'(bus.ex_valid), 1);
    chk("add_data1", bus.ex_reg_data1, 32'hDEADBEEF);
    chk("add_data2_x0", bus.ex_reg_data2, 0);
    chk("add_rd", 32'(bus.ex_rd), 1);
    chk("add_rs1", 32'(bus.ex_rs1), 5);
    chk("add_pc", bus.ex_pc, 32'h100);
    chk("add_opcode", 32'(bus.ex_opcode), 32'h33);

    // Immediate formats
    drive(32'h104, ADDI_6_5_M); tick();
    chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);
    chk("addi_rd", 32'(bus.ex_rd), 6);
    drive(32'h108, BEQ_M4); tick();
    chk("beq_imm", bus.ex_imm, 32'hFFFFFFFC);
    drive(32'h10C, LUI_8); tick();
    bus.id_valid = 1'b0;
    chk("lui_imm", bus.ex_imm, 32'h12345000);
    chk("lui_rd", 32'(bus.ex_rd), 8);

    // Load-use: one bubble
    drive(32'h200, LW_3_2); tick();
    chk("lw_data1", bus.ex_reg_data1, 32'h200);
    drive(32'h204, ADD_4_3_1);
    chk("lu_id_ready_low", 32'(bus.id_ready), 0);
    tick();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
    chk("lu_stall_cnt", 32'(stall_cnt), 1);
    chk("lu_id_ready_back", 32'(bus.id_ready), 1);
    tick();
    bus.id_valid = 1'b0;
    chk("lu_add_valid", 32'(bus.ex_valid), 1);
    chk("lu_add_pc", bus.ex_pc, 32'h204);
    chk("lu_add_data2", bus.ex_reg_data2, 32'h11);

    // Load to x0 never stalls
    drive(32'h208, LW_0_2); tick();
    drive(32'h20C, ADD_4_0_1);
    chk("lw0_id_ready", 32'(bus.id_ready), 1);
    tick();
    chk("lw0_add_valid", 32'(bus.ex_valid), 1);
    chk("lw0_add_pc", bus.ex_pc, 32'h20C);
    chk("lw0_x0_reads_zero", bus.ex_reg_data1, 0);
    chk("lw0_stall_cnt", 32'(stall_cnt), 1);

    // Backpressure: hold 3 cycles, issue on release
    bus.ex_ready = 1'b0;
    drive(32'h300, ADDI_6_5_M);
    chk("bp_id_ready", 32'(bus.id_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_pc", bus.ex_pc, 32'h20C);
      chk("bp_hold_rd", 32'(bus.ex_rd), 4);
      chk("bp_hold_valid", 32'(bus.ex_valid), 1);
      chk("bp_hold_id_ready", 32'(bus.id_ready), 0);
    end
    bus.ex_ready = 1'b1;
    #1;
    chk("bp_release_id_ready", 32'(bus.id_ready), 1);
    tick();
    bus.id_valid = 1'b0;
    chk("bp_issue_pc", bus.ex_pc, 32'h300);

    // Flush over a pending load-use hazard
    drive(32'h400, LW_3_2); tick();
    flush = 1'b1;
    drive(32'h404, ADD_4_3_1);
    chk("flush_id_ready", 32'(bus.id_ready), 1);
    tick();
    flush = 1'b0;
    bus.id_valid = 1'b0;
    chk("flush_ex_valid", 32'(bus.ex_valid), 0);
    chk("flush_stall_cnt", 32'(stall_cnt), 1);

    // Same-cycle write-back and read of x7
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
    drive(32'h500, ADDI_9_7_0);
    tick();
    wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_same_cycle", bus.ex_reg_data1, 32'h1234);
`else
    chk("wb_same_cycle", bus.ex_reg_data1, 32'h77);
`endif
    drive(32'h504, ADDI_9_7_0); tick();
    bus.id_valid = 1'b0;
    chk("wb_next_cycle", bus.ex_reg_data1, 32'h1234);

    // Counter saturates at all-ones
    exp_cnt = 1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h800, LW_3_2); tick();
      drive(32'h804, ADD_4_3_1); tick(); tick();
      bus.id_valid = 1'b0;
      exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
      chk("sat_stall_cnt", 32'(stall_cnt), exp_cnt);
    end

    // Asynchronous reset mid-stream
    drive(32'h600, ADD_1_5_0); tick();
    bus.id_valid = 1'b0;
    chk("arst_pre_valid", 32'(bus.ex_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(bus.ex_valid), 0);
    chk("arst_ex_pc", bus.ex_pc, 0);
    chk("arst_ex_rd", 32'(bus.ex_rd), 0);
    chk("arst_ex_data1", bus.ex_reg_data1, 0);
    chk("arst_stall_cnt", 32'(stall_cnt), 0);
    rst = 1'b1;
    tick();
    drive(32'h700, ADD_1_5_0); tick();
    bus.id_valid = 1'b0;
    chk("arst_regfile_cleared", bus.ex_reg_data1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Parametrised decode stage that merges instruction decode, the register file and the ID/EX pipeline register into one block, with valid/ready flow control. It detects load-use hazards internally and inserts a bubble for them, and it supports a synchronous flush for taken branches. It sits between the IF/ID register and the execute stage and takes the write-back port from the WB stage.

Parameters:
WIDTH, 32, datapath width in bits; must be 32 or more; immediates are sign-extended to WIDTH.
NUM_REGS, 32, architectural register count; must be a power of 2, 2 to 32; x0 reads as zero.
CNT_W, 16, width of the stall-event counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
id_valid  in  1  IF/ID holds a valid instruction
id_ready  out  1  decode accepts the instruction this cycle
id_pc  in  WIDTH  PC of the instruction in ID
id_instr  in  32  RV32I instruction word
flush  in  1  kill the instruction in ID and in ID/EX (taken branch)
wb_en  in  1  register write enable
wb_rd  in  $clog2(NUM_REGS)  write address
wb_data  in  WIDTH  write data
ex_ready  in  1  execute stage accepts the ID/EX contents
ex_valid  out  1  ID/EX register holds a valid instruction
ex_pc, ex_reg_data1, ex_reg_data2, ex_imm  out  WIDTH  registered PC, operand values and immediate
ex_rs1, ex_rs2, ex_rd  out  $clog2(NUM_REGS)  registered register indices
ex_funct3  out  3  registered funct3
ex_funct7  out  7  registered funct7
ex_opcode  out  7  registered opcode
stall_cnt  out  CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output is 0 (ex_valid=0), all registers are 0, stall_cnt=0.
- Register file:
  - 2 combinational read ports, 1 synchronous write port.
  - A write to x0 is ignored; x0 always reads 0.
  - Register indices use the low $clog2(NUM_REGS) bits of each instruction field.
- Decode: standard RV32I field extraction. Immediate selection by opcode:
  - I-type: 0000011, 0010011, 1100111
  - S-type: 0100011
  - B-type: 1100011
  - U-type: 0110111, 0010111
  - J-type: 1101111
  - any other opcode: 0
- Operand use:
  - uses_rs1 = opcode is not in {0110111, 0010111, 1101111}.
  - uses_rs2 = opcode is in {0110011, 0100011, 1100011}.
- Advance condition: adv = !ex_valid || ex_ready.
- Hazard: hazard = ex_valid && ex_opcode==0000011 && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
- id_ready (combinational) = flush || (adv && !hazard).
- ID/EX update on each rising edge, in priority order:
  - flush: ex_valid<=0; the instruction in ID is consumed and dropped.
  - else if adv && hazard && id_valid: bubble; ex_valid<=0, stall_cnt += 1 (saturates at all-ones); the IF/ID contents are held.
  - else if adv: ex_valid<=id_valid; all ex_* fields load from decode.
  - else: hold all ex_* outputs.
- Latency: 1 cycle from id_valid && id_ready to ex_valid.
- A load-use pair always produces exactly one bubble.
- Payload fields are don't-care while ex_valid=0 but must hold stable while ex_valid && !ex_ready.
- Simultaneous write-back and read of the same register: see Optional Feature.

Optional Feature:
DECODE_WB_BYPASS_EN
- Defined: if wb_en && wb_rd!=0 && wb_rd==rs1 (or rs2) in the same cycle, the read port returns wb_data (write-through).
- Undefined: the read port returns the stored (old) value, and the hazard unit is unchanged.
- Tests that depend on write-through are guarded by the same macro.

Test Plan:
- Reset mid-stream: drive rst=0 while ex_valid=1 -> all ex_* outputs and stall_cnt read 0 immediately, with no clock edge needed.
- Write x5=0xDEADBEEF, then issue ADD x1,x5,x0 with pc 0x100 -> next cycle ex_valid=1, ex_reg_data1=0xDEADBEEF, ex_rd=1, ex_pc=0x100.
- LW x3,0(x2) followed by ADD x4,x3,x1 -> exactly 1 bubble; id_ready=0 for one cycle; stall_cnt=1; the ADD reaches EX one cycle late. LW x0 followed by ADD x4,x0,x1 -> no bubble.
- ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* outputs stable, id_ready=0; the held instruction issues on the first cycle ex_ready=1.
- Assert flush together with id_valid=1 -> id_ready=1, ex_valid=0 next cycle, stall_cnt unchanged.
- With DECODE_WB_BYPASS_EN: wb_en=1, wb_rd=7, wb_data=0x1234 in the same cycle as reading x7 -> ex_reg_data1=0x1234. Without the macro -> the old value of x7.
